// File: rtl/regfile_bist_pkg.sv
// Shared types, sizes and the expected-data rule for the register-file BIST.
package regfile_bist_pkg;

  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Data expected in register r during pass p. Pass 1 uses the complemented
  // pattern. The register index is XORed in so that address aliasing shows
  // up as a data error. When zero_override is set, register 0 is expected to
  // read 0. Write data is generated with zero_override cleared.
  function automatic logic [DATA_W-1:0] exp_val(
    input logic [DATA_W-1:0] pattern,
    input logic              pass_idx,
    input logic [ADDR_W-1:0] r,
    input logic              zero_override
  );
    logic [DATA_W-1:0] base;
    base = pass_idx ? ~pattern : pattern;
    if (zero_override && (r == '0)) begin
      return '0;
    end
    return base ^ {{(DATA_W-ADDR_W){1'b0}}, r};
  endfunction

endpackage

// File: rtl/regfile_bist_ctr.sv
// Register-index, pass-index and read-latency counters for the BIST march.
// Both the current and the next-cycle values are exported. This lets the
// parent register its outputs from the values the counters will hold next.
module regfile_bist_ctr
  import regfile_bist_pkg::*;
#(
  parameter int READ_LATENCY = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clr,        // restart at pass 0, register 0
  input  logic              adv_write,  // one register written this cycle
  input  logic              adv_read,   // one read-slot cycle consumed
  input  logic              set_pass,   // move on to pass 1
  output logic [ADDR_W-1:0] r,
  output logic [ADDR_W-1:0] r_next,
  output logic              p,
  output logic              p_next,
  output logic              r_last,
  output logic              slot_last
);

  localparam logic [1:0] LAT_LAST = 2'(READ_LATENCY);

  logic [1:0] lat;
  logic [1:0] lat_next;

  assign r_last    = (r == ADDR_W'(NUM_REGS - 1));
  assign slot_last = (lat == LAT_LAST);

  // Next-value logic. The register index wraps 31 -> 0 naturally.
  always_comb begin
    r_next   = r;
    p_next   = p;
    lat_next = lat;
    if (clr) begin
      r_next   = '0;
      p_next   = 1'b0;
      lat_next = '0;
    end else begin
      if (adv_write) begin
        r_next   = r + 1'b1;
        lat_next = '0;
      end
      if (adv_read) begin
        if (slot_last) begin
          lat_next = '0;
          r_next   = r + 1'b1;
        end else begin
          lat_next = lat + 1'b1;
        end
      end
      if (set_pass) begin
        p_next = 1'b1;
      end
    end
  end

  // Counter state registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r   <= '0;
      p   <= 1'b0;
      lat <= '0;
    end else begin
      r   <= r_next;
      p   <= p_next;
      lat <= lat_next;
    end
  end

endmodule

// File: rtl/regfile_bist.sv
// Two-pass write/read-back march over the 32x32 register file through its
// test port. The block reports pass/fail, the first failing register and the
// data observed there.
//
// Start/done protocol: start is a level. It is sampled on every rising edge
// while the block is IDLE or DONE, and ignored while busy. done is a level
// that stays high, with pass/fail_reg/fail_data stable, until the next start
// is accepted or reset is asserted.
module regfile_bist
  import regfile_bist_pkg::*;
#(
  parameter logic [DATA_W-1:0] PATTERN            = 32'hA5A5_5A5A,
  parameter int                READ_LATENCY       = 1,
  parameter bit                ZERO_REG_HARDWIRED = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic              test,
  output logic              t_ctrl_writeEnable,
  output logic [ADDR_W-1:0] t_ctrl_writeReg,
  output logic [ADDR_W-1:0] t_ctrl_readRegA,
  output logic [ADDR_W-1:0] t_ctrl_readRegB,
  output logic [DATA_W-1:0] t_data_writeReg,
  input  logic [DATA_W-1:0] t_data_readRegA,
  input  logic [DATA_W-1:0] t_data_readRegB,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_reg,
  output logic [DATA_W-1:0] fail_data
);

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] r;
  logic [ADDR_W-1:0] r_next;
  logic              p;
  logic              p_next;
  logic              r_last;
  logic              slot_last;
  logic              clr;
  logic              adv_write;
  logic              adv_read;
  logic              set_pass;
  logic              fail_hit;
  logic              pass_hit;
  logic              mis_a;
  logic              mis_b;
  logic              busy_next;

  regfile_bist_ctr #(
    .READ_LATENCY(READ_LATENCY)
  ) u_ctr (
    .clock     (clock),
    .reset     (reset),
    .clr       (clr),
    .adv_write (adv_write),
    .adv_read  (adv_read),
    .set_pass  (set_pass),
    .r         (r),
    .r_next    (r_next),
    .p         (p),
    .p_next    (p_next),
    .r_last    (r_last),
    .slot_last (slot_last)
  );

  // Port A reads register r and port B reads register 31-r (which is ~r).
  assign mis_a = (t_data_readRegA != exp_val(PATTERN, p, r, ZERO_REG_HARDWIRED));
  assign mis_b = (t_data_readRegB != exp_val(PATTERN, p, ~r, ZERO_REG_HARDWIRED));
  assign busy_next = (state_next == ST_WRITE) || (state_next == ST_READ);

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and counter control. The read compare happens only in the
  // last cycle of each slot.
  always_comb begin
    state_next = state;
    clr        = 1'b0;
    adv_write  = 1'b0;
    adv_read   = 1'b0;
    set_pass   = 1'b0;
    fail_hit   = 1'b0;
    pass_hit   = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          clr        = 1'b1;
          state_next = ST_WRITE;
        end
      end
      ST_WRITE: begin
        adv_write = 1'b1;
        if (r_last) begin
          state_next = ST_READ;
        end
      end
      ST_READ: begin
        if (slot_last && (mis_a || mis_b)) begin
          fail_hit   = 1'b1;
          state_next = ST_DONE;
        end else begin
          adv_read = 1'b1;
          if (slot_last && r_last) begin
            if (!p) begin
              set_pass   = 1'b1;
              state_next = ST_WRITE;
            end else begin
              pass_hit   = 1'b1;
              state_next = ST_DONE;
            end
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Registered outputs. They are loaded from next-cycle state and counter
  // values, so each output lines up with the state it describes and no input
  // reaches an output without passing through a flop.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      test               <= 1'b0;
      busy               <= 1'b0;
      done               <= 1'b0;
      pass               <= 1'b0;
      t_ctrl_writeEnable <= 1'b0;
      t_ctrl_writeReg    <= '0;
      t_ctrl_readRegA    <= '0;
      t_ctrl_readRegB    <= '0;
      t_data_writeReg    <= '0;
      fail_reg           <= '0;
      fail_data          <= '0;
    end else begin
      test               <= busy_next;
      busy               <= busy_next;
      done               <= (state_next == ST_DONE);
      t_ctrl_writeEnable <= (state_next == ST_WRITE);
      if (state_next == ST_WRITE) begin
        t_ctrl_writeReg <= r_next;
        t_data_writeReg <= exp_val(PATTERN, p_next, r_next, 1'b0);
      end
      if (state_next == ST_READ) begin
        t_ctrl_readRegA <= r_next;
        t_ctrl_readRegB <= ~r_next;
      end
      if (clr) begin
        pass      <= 1'b0;
        fail_reg  <= '0;
        fail_data <= '0;
      end
      if (pass_hit) begin
        pass <= 1'b1;
      end
      if (fail_hit) begin
        fail_reg  <= r;
        fail_data <= mis_a ? t_data_readRegA : t_data_readRegB;
      end
    end
  end

endmodule

// File: tb/tb_regfile_bist.sv
// Bench for regfile_bist: a behavioural register file with injectable faults
// and a march reference model that predicts each run's outcome.
module tb_regfile_bist;

  localparam logic [31:0] PATTERN  = 32'hA5A5_5A5A;
  localparam int          LAT      = 1;
  localparam int          SLOT     = LAT + 1;
  localparam int          PASS_CYC = 32 * (LAT + 2);

  localparam int F_NONE  = 0;  // healthy, reg 0 hardwired
  localparam int F_STUCK = 1;  // one bit of one register stuck
  localparam int F_BZERO = 2;  // port B returns 0 for one register
  localparam int F_ZWRITE = 3; // reg 0 is writable

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        test;
  logic        t_ctrl_writeEnable;
  logic [4:0]  t_ctrl_writeReg;
  logic [4:0]  t_ctrl_readRegA;
  logic [4:0]  t_ctrl_readRegB;
  logic [31:0] t_data_writeReg;
  logic [31:0] t_data_readRegA;
  logic [31:0] t_data_readRegB;
  logic        busy;
  logic        done;
  logic        pass;
  logic [4:0]  fail_reg;
  logic [31:0] fail_data;

  int   fault_kind = F_NONE;
  int   fault_reg  = 0;
  int   fault_bit  = 0;
  logic fault_val  = 1'b0;

  logic [31:0] mem [32];
  int  total = 0;
  int  bad   = 0;
  int  viol  = 0;
  int  test_cnt = 0;
  bit  mon_on = 1'b0;
  logic [31:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  regfile_bist dut (
    .clock              (clock),
    .reset              (reset),
    .start              (start),
    .test               (test),
    .t_ctrl_writeEnable (t_ctrl_writeEnable),
    .t_ctrl_writeReg    (t_ctrl_writeReg),
    .t_ctrl_readRegA    (t_ctrl_readRegA),
    .t_ctrl_readRegB    (t_ctrl_readRegB),
    .t_data_writeReg    (t_data_writeReg),
    .t_data_readRegA    (t_data_readRegA),
    .t_data_readRegB    (t_data_readRegB),
    .busy               (busy),
    .done               (done),
    .pass               (pass),
    .fail_reg           (fail_reg),
    .fail_data          (fail_data)
  );

  // ---------------- environment ----------------
  function automatic logic [31:0] raw_pat(int p, int r);
    logic [31:0] base;
    base = (p == 0) ? PATTERN : ~PATTERN;
    return base ^ 32'(r);
  endfunction

  // What a correct BIST must expect (reg 0 reads 0).
  function automatic logic [31:0] want(int p, int r);
    if (r == 0) return 32'h0;
    return raw_pat(p, r);
  endfunction

  function automatic logic [31:0] faulty(int addr, logic [31:0] v, bit port_b);
    logic [31:0] o;
    o = v;
    if (fault_kind == F_STUCK && addr == fault_reg) o[fault_bit] = fault_val;
    if (fault_kind == F_BZERO && port_b && addr == fault_reg) o = 32'h0;
    return o;
  endfunction

  function automatic logic [31:0] stored(int addr);
    if (addr == 0 && fault_kind != F_ZWRITE) return 32'h0;
    return mem[addr];
  endfunction

  // Behavioural register file with a one-cycle registered read.
  logic [31:0] rd_a, rd_b;
  always @(posedge clock) begin
    if (t_ctrl_writeEnable && (t_ctrl_writeReg != 5'd0 || fault_kind == F_ZWRITE))
      mem[t_ctrl_writeReg] <= t_data_writeReg;
    rd_a <= faulty(int'(t_ctrl_readRegA), stored(int'(t_ctrl_readRegA)), 1'b0);
    rd_b <= faulty(int'(t_ctrl_readRegB), stored(int'(t_ctrl_readRegB)), 1'b1);
  end
  assign t_data_readRegA = rd_a;
  assign t_data_readRegB = rd_b;

  // Protocol monitor, sampled on the falling edge.
  always @(negedge clock) begin
    if (mon_on) begin
      if (test) test_cnt++;
      if (test !== busy) viol++;
      if (t_ctrl_writeEnable && !busy) viol++;
      if (done && busy) viol++;
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference march: after pass p every register r holds raw_pat(p, r) unless
  // it is hardwired to 0. Scan slots in order and stop at the first mismatch.
  // Queued: pass, fail_reg, fail_data, done cycle (start edge is cycle 1).
  task automatic model_run();
    bit          found;
    int          fr, fc;
    logic [31:0] fd, oa, ob;
    found = 1'b0;
    fr = 0; fc = 0; fd = 32'h0;
    for (int p = 0; p < 2; p++) begin
      for (int r = 0; r < 32; r++) begin
        if (!found) begin
          oa = faulty(r, (r == 0 && fault_kind != F_ZWRITE) ? 32'h0 : raw_pat(p, r), 1'b0);
          ob = faulty(31 - r, (r == 31 && fault_kind != F_ZWRITE) ? 32'h0 : raw_pat(p, 31 - r), 1'b1);
          if (oa !== want(p, r) || ob !== want(p, 31 - r)) begin
            found = 1'b1;
            fr = r;
            fd = (oa !== want(p, r)) ? oa : ob;
            fc = p * PASS_CYC + 32 + (r + 1) * SLOT + 1;
          end
        end
      end
    end
    if (found) begin
      exp_q.push_back(32'd0); exp_q.push_back(32'(fr));
      exp_q.push_back(fd);    exp_q.push_back(32'(fc));
    end else begin
      exp_q.push_back(32'd1); exp_q.push_back(32'd0);
      exp_q.push_back(32'd0); exp_q.push_back(32'(2 * PASS_CYC + 1));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic check_zero(input string tag);
    check_eq({tag, ":flags"}, {59'd0, test, busy, done, pass, t_ctrl_writeEnable}, 64'd0);
    check_eq({tag, ":addr"}, {44'd0, t_ctrl_writeReg, t_ctrl_readRegA, t_ctrl_readRegB, fail_reg}, 64'd0);
    check_eq({tag, ":data"}, {t_data_writeReg, fail_data}, 64'd0);
  endtask

  task automatic run_case(input string name, input int kind, input int freg,
                          input int fbit, input logic fval, input bit hold);
    int cyc;
    logic [31:0] e_pass, e_reg, e_data, e_cyc;
    fault_kind = kind; fault_reg = freg; fault_bit = fbit; fault_val = fval;
    model_run();
    e_pass = exp_q.pop_front(); e_reg = exp_q.pop_front();
    e_data = exp_q.pop_front(); e_cyc = exp_q.pop_front();
    test_cnt = 0; viol = 0; mon_on = 1'b1;
    @(negedge clock); start = 1'b1;
    @(posedge clock); cyc = 1;
    @(negedge clock); if (!hold) start = 1'b0;
    while (!done && cyc < 2000) begin
      @(posedge clock); cyc++;
      @(negedge clock);
    end
    mon_on = 1'b0;
    check_eq({name, ":done_cycle"}, 64'(cyc), 64'(e_cyc));
    check_eq({name, ":pass"}, 64'(pass), 64'(e_pass));
    check_eq({name, ":fail_reg"}, 64'(fail_reg), 64'(e_reg));
    check_eq({name, ":fail_data"}, 64'(fail_data), 64'(e_data));
    check_eq({name, ":test_cycles"}, 64'(test_cnt), 64'(e_cyc - 1));
    check_eq({name, ":protocol"}, 64'(viol), 64'd0);
    if (hold) begin
      // start still high in DONE: the next edge must re-enter WRITE
      @(posedge clock); @(negedge clock);
      check_eq({name, ":restart_busy"}, 64'(busy), 64'd1);
      check_eq({name, ":restart_done"}, 64'(done), 64'd0);
      start = 1'b0;
      reset = 1'b1; @(negedge clock); reset = 1'b0;
    end
  endtask

  task automatic reset_mid_run();
    fault_kind = F_NONE;
    @(negedge clock); start = 1'b1;
    @(posedge clock);
    @(negedge clock); start = 1'b0;
    repeat (38) @(negedge clock);
    check_eq("midrun:busy", 64'(busy), 64'd1);
    reset = 1'b1;
    @(negedge clock);
    check_zero("midrun_reset");
    reset = 1'b0;
    @(negedge clock);
    check_zero("midrun_after");
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clock);
    check_zero("por");
    reset = 1'b0;
    @(negedge clock);
    check_zero("idle");

    run_case("clean", F_NONE, 0, 0, 1'b0, 1'b0);
    run_case("stuck7b3", F_STUCK, 7, 3, 1'b0, 1'b0);
    check_eq("stuck7b3:lit", 64'(fail_data), 64'h0000_0000_A5A5_5A55);
    run_case("bport31", F_BZERO, 31, 0, 1'b0, 1'b0);
    run_case("zwrite", F_ZWRITE, 0, 0, 1'b0, 1'b0);
    check_eq("zwrite:lit", 64'(fail_data), 64'h0000_0000_A5A5_5A5A);
    reset_mid_run();
    run_case("after_reset", F_NONE, 0, 0, 1'b0, 1'b0);
    run_case("held_start", F_NONE, 0, 0, 1'b0, 1'b1);

    for (int i = 0; i < 10; i++) begin
      run_case($sformatf("rand%0d", i), int'($urandom_range(0, 3)),
               int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
               logic'($urandom_range(0, 1)), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
